// File: rtl/sdram_test_gen_chk_pkg.sv
// ---------------------------------------------------------------------------
// sdram_test_gen_chk_pkg
// Shared definitions for the SDRAM self-test generator/checker:
//   state_t  - test sequencer states (3-bit, IDLE=0 .. DONE=5)
//   OFFSET_W - width of the per-pass pattern offset (the pass counter)
//   IDX_W    - width of the word index inside one pass
// ---------------------------------------------------------------------------
package sdram_test_gen_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_GAP   = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int OFFSET_W = 4;
    localparam int IDX_W    = 16;

endpackage

// File: rtl/sdram_test_chk.sv
// ---------------------------------------------------------------------------
// sdram_test_chk
// Read-back checker. Regenerates the expected word for every issued read,
// carries it one cycle alongside the read valid so it lines up with the
// registered FIFO output, and latches a sticky error on any mismatch.
// Ports:
//   clk_50m, rst_n   - clock, asynchronous active-low reset
//   rd_en            - read strobe issued to the FIFO this cycle
//   rd_idx           - word index of that read within the pass
//   pass_offset      - pass counter value used for the pattern offset
//   rd_data          - FIFO read word (valid the cycle after rd_en)
//   error_flag       - sticky mismatch flag, cleared only by reset
// ---------------------------------------------------------------------------
module sdram_test_chk
    import sdram_test_gen_chk_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                clk_50m,
    input  logic                rst_n,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_idx,
    input  logic [OFFSET_W-1:0] pass_offset,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                error_flag
);

    function automatic logic [DATA_W-1:0] pattern_word(
        input logic [IDX_W-1:0]    k,
        input logic [OFFSET_W-1:0] p
    );
        logic [DATA_W-1:0] off;
        off = {p, {(DATA_W-OFFSET_W){1'b0}}};
        return DATA_W'(k) + off;
    endfunction

    logic              vld_p1;
    logic [DATA_W-1:0] exp_p1;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            exp_p1     <= '0;
            error_flag <= 1'b0;
        end else begin
            // p0 -> p1: read issued, expected word travels with its valid
            vld_p1 <= rd_en;
            if (rd_en) begin
                exp_p1 <= pattern_word(rd_idx, pass_offset);
            end
            // p1 -> flag: FIFO word now valid, compare and stick
            if (vld_p1 && (rd_data != exp_p1)) begin
                error_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_test_gen_chk.sv
// ---------------------------------------------------------------------------
// sdram_test_gen_chk
// Self-test traffic source for the SDRAM FIFO-port controller. After
// init_done it repeatedly writes WORDS pattern words, waits GAP_CYCLES for
// the controller to flush, reads the block back and checks every word.
// Ports:
//   clk_50m, rst_n       - 50 MHz clock, asynchronous active-low reset
//   init_done            - SDRAM init complete, only looked at in IDLE
//   wr_full / wr_en / wr_data   - write FIFO handshake and word
//   rd_empty / rd_en / rd_data  - read FIFO handshake and word
//   error_flag           - sticky compare failure
//   cycle_countor        - completed passes, wraps 15 -> 0
//   test_busy            - high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module sdram_test_gen_chk
    import sdram_test_gen_chk_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int WORDS      = 1024,
    parameter int GAP_CYCLES = 256
) (
    input  logic                clk_50m,
    input  logic                rst_n,
    input  logic                init_done,
    input  logic                wr_full,
    output logic                wr_en,
    output logic [DATA_W-1:0]   wr_data,
    input  logic                rd_empty,
    output logic                rd_en,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                error_flag,
    output logic [OFFSET_W-1:0] cycle_countor,
    output logic                test_busy
);

    localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    function automatic logic [DATA_W-1:0] pattern_word(
        input logic [IDX_W-1:0]    k,
        input logic [OFFSET_W-1:0] p
    );
        logic [DATA_W-1:0] off;
        off = {p, {(DATA_W-OFFSET_W){1'b0}}};
        return DATA_W'(k) + off;
    endfunction

    state_t           state;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [GAP_W-1:0] gap_cnt;

    // Strobes are gated by the FIFO flags in the same cycle, so a full or
    // empty FIFO never sees a strobe and no word is dropped or repeated.
    // They derive only from registered state, so reset removes them at once.
    assign wr_en     = (state == ST_WRITE) && !wr_full;
    assign rd_en     = (state == ST_READ) && !rd_empty;
    assign wr_data   = wr_en ? pattern_word(wr_idx, cycle_countor) : '0;
    assign test_busy = (state != ST_IDLE);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            wr_idx        <= '0;
            rd_idx        <= '0;
            gap_cnt       <= '0;
            cycle_countor <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (init_done) begin
                        state  <= ST_WRITE;
                        wr_idx <= '0;
                    end
                end
                ST_WRITE: begin
                    if (wr_en) begin
                        wr_idx <= wr_idx + IDX_W'(1);
                        if (wr_idx == LAST_IDX) begin
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        state  <= ST_READ;
                        rd_idx <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_READ: begin
                    if (rd_en) begin
                        rd_idx <= rd_idx + IDX_W'(1);
                        if (rd_idx == LAST_IDX) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                // Last read word arrives during DRAIN; the checker compares it
                // on the edge into DONE, before the offset changes.
                ST_DRAIN: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    cycle_countor <= cycle_countor + OFFSET_W'(1);
                    state         <= ST_WRITE;
                    wr_idx        <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sdram_test_chk #(
        .DATA_W(DATA_W)
    ) u_chk (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .rd_en       (rd_en),
        .rd_idx      (rd_idx),
        .pass_offset (cycle_countor),
        .rd_data     (rd_data),
        .error_flag  (error_flag)
    );

endmodule
